// File: rtl/sdrd_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sdrd_pkg : shared types/constants for the SDRD serial-read capture path |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package sdrd_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdrd_bit_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sdrd_bit_timer : phase counter producing per-bit strobe/sample pulses   |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module sdrd_bit_timer
  import sdrd_pkg::*;
#(
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic strobe,
  output logic sample
);

  localparam int PHASE_W = cnt_width(SETTLE + 1);

  logic [PHASE_W-1:0] phase;
  logic               phase_last;

  assign phase_last = (phase == PHASE_W'(SETTLE));

  // Phase sits at 0 whenever disabled so every read starts with a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= '0;
    else if (!en || phase_last)
      phase <= '0;
    else
      phase <= phase + 1'b1;
  end

  assign strobe = en && (phase == '0);
  assign sample = en && phase_last;

endmodule
`default_nettype wire

// File: rtl/sdrd_capture.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sdrd_capture : strobe/sample SDRD bits into a word, valid/ack handoff   |
// | Option macro : SDRD_CAPTURE_PARITY_EN (trailing even-parity bit, perr)  |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module sdrd_capture
  import sdrd_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sdrd,
  output logic             seq_strobe,
  output logic             busy,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ack,
  output logic             overrun,
  output logic             perr
);

`ifdef SDRD_CAPTURE_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BIT_W = cnt_width(WIDTH + 2);

  state_t             state, state_nx;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   data_nx;
  logic               sample;
  logic               last_sample;
  logic               hold_ack;

  sdrd_bit_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state == ST_SHIFT),
    .strobe (seq_strobe),
    .sample (sample)
  );

  assign last_sample = sample && (bit_cnt == BIT_W'(NBITS - 1));
  assign hold_ack    = (state == ST_HOLD) && rd_ack;
  assign busy        = (state == ST_SHIFT);
  assign rd_valid    = (state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)       state_nx = ST_SHIFT;
      ST_SHIFT: if (last_sample) state_nx = ST_HOLD;
      ST_HOLD:  if (rd_ack)      state_nx = start ? ST_SHIFT : ST_IDLE;
      default:                   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bit_cnt <= '0;
    else if (state != ST_SHIFT)
      bit_cnt <= '0;
    else if (sample)
      bit_cnt <= bit_cnt + 1'b1;
  end

  // Only the addressed data bit changes; the parity slot writes nothing.
  always_comb begin
    data_nx = rd_data;
    for (int i = 0; i < WIDTH; i++)
      if (bit_cnt == BIT_W'(i)) data_nx[i] = sdrd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (sample)
      rd_data <= data_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (hold_ack)
      overrun <= 1'b0;
    else if ((state == ST_HOLD) && start)
      overrun <= 1'b1;
  end

`ifdef SDRD_CAPTURE_PARITY_EN
  // At the last sample sdrd carries the parity bit and rd_data is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perr <= 1'b0;
    else if (last_sample)
      perr <= (^rd_data) ^ sdrd;
    else if (hold_ack)
      perr <= 1'b0;
  end
`else
  assign perr = 1'b0;
`endif

endmodule
`default_nettype wire
